bank_arbiter: RTL and testbench
===============================

BANK_ARBITER -- requirements
Module: bank_arbiter

Interface
REQ-001 Parameter NUM_BANKS, default 4: number of bank requesters sharing one router injection port; at least 2.
REQ-002 Parameter DONE_TARGET, default NUM_BANKS: count of CTRL_DONE packets delivered to the router before the run is complete; at least 1.
REQ-003 Port clk  input  1  sole clock; all state on posedge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port bank_valid  input  NUM_BANKS  per-bank packet-offer strobe.
REQ-006 Port bank_ready  output  NUM_BANKS  per-bank accept; at most one bit high per cycle.
REQ-007 Port bank_pkt  input  pkt_t x NUM_BANKS  per-bank packet (types::pkt_t).
REQ-008 Port router_valid  output  1  output register holds a packet.
REQ-009 Port router_ready  input  1  router accepts this cycle.
REQ-010 Port router_pkt  output  pkt_t  registered packet to the router.
REQ-011 Port grant_idx  output  clog2(NUM_BANKS)  index of the last bank whose packet was accepted; debug use.
REQ-012 Port all_done  output  1  sticky run-complete flag.

Function
REQ-013 Transfers: bank i transfers when bank_valid[i] and bank_ready[i] are both high; the router transfers when router_valid and router_ready are both high.
REQ-014 Output stage is a one-entry register (state EMPTY/FULL); router_valid equals FULL; router_pkt is driven only from the register.
REQ-015 Accept slot: open iff (EMPTY or (FULL and router_ready)) and all_done is low; with no slot open, bank_ready is all-zero.
REQ-016 Grant: with the slot open, bank_ready is set one-hot on winner g, selected from valid banks only; no valid bank -> bank_ready all-zero.
REQ-017 Priority class: if any valid bank offers ctrl==CTRL_DONE, only CTRL_DONE offers compete; otherwise all valid banks compete.
REQ-018 Round-robin within class: search starts at rr_ptr+1 modulo NUM_BANKS and wraps; on an accept, rr_ptr <= g and grant_idx <= g.
REQ-019 Accept at cycle t: packet loads into the register at the t edge; router_valid is high from t+1, giving one-cycle latency.
REQ-020 Simultaneous drain and accept: on the same edge the old packet leaves and the new one loads; router_valid stays high, for sustained 1 packet/cycle throughput.
REQ-021 Backpressure: while FULL and router_ready is low, router_pkt and router_valid stay stable and rr_ptr does not change.
REQ-022 A valid bank that is not granted keeps its offer; the arbiter does not need its packet stable, since each cycle is re-arbitrated.
REQ-023 Done counter: width clog2(DONE_TARGET+1); increments on each router transfer with router_pkt.ctrl==CTRL_DONE; saturates at DONE_TARGET.
REQ-024 all_done is set on the edge where the counter reaches DONE_TARGET; it stays high until reset; from then on no bank is accepted.
REQ-025 A packet already in the register when all_done rises is still presented to the router until transferred.
REQ-026 Fairness: any bank holding bank_valid continuously is accepted within NUM_BANKS accept slots of its class.

Reset
REQ-027 rst asserted: immediately, without waiting for a clock edge, router_valid=0, bank_ready=0, all_done=0, grant_idx=0, rr_ptr=NUM_BANKS-1 (so bank 0 wins first), done counter=0, output register EMPTY.
REQ-028 rst asserted mid-transfer: the held packet is discarded and never presented; the first accept after release occurs on the first clock edge with rst low.

Verification
REQ-029 All four banks valid with non-DONE packets, router_ready=1 -> accepts in order 0,1,2,3,0; router_valid high every cycle from the second; each packet appears exactly one cycle after its accept.
REQ-030 Banks 1 and 3 valid, router_ready=0 for 5 cycles after the first accept -> the bank 1 packet is held stable on router_pkt for 5 cycles; bank_ready=0 for those 5 cycles; bank 3 is accepted on the cycle router_ready returns.
REQ-031 Bank 0 non-DONE and bank 2 CTRL_DONE, both valid, rr_ptr=3 -> bank 2 is granted first despite bank 0 being next in rotation.
REQ-032 DONE_TARGET=4: deliver 4 CTRL_DONE packets with 1-cycle router stalls between them -> all_done rises on the edge of the 4th router transfer; later bank_valid offers see bank_ready=0.
REQ-033 rst asserted asynchronously between edges while FULL -> router_valid drops within the same cycle; after release, bank 0 wins the first accept.
REQ-034 Random valid, random ready and a random CTRL_DONE mix, checked against a reference model -> no loss, no duplication, at most one-hot bank_ready, and the REQ-026 bound holds.

Source files
------------

// File: rtl/bank_arbiter.sv
// -----------------------------------------------------------------------------
// bank_arbiter
//   Shares one router injection port between NUM_BANKS bank requesters.
//   Offers carrying CTRL_DONE pre-empt all other offers. Inside the winning
//   class, banks are served round-robin starting after the last accepted bank.
//   Accepted packets go through a one-entry output register: one cycle of
//   latency, one packet per cycle under sustained traffic. Once DONE_TARGET
//   CTRL_DONE packets have reached the router, the run is complete and no
//   further bank is accepted.
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous, active-high reset
//   bank_valid    per-bank offer strobe
//   bank_ready    per-bank accept, one-hot or zero
//   bank_pkt      per-bank packet
//   router_valid  output register holds a packet
//   router_ready  router accepts this cycle
//   router_pkt    registered packet to the router
//   grant_idx     last accepted bank (debug)
//   all_done      sticky run-complete flag
// -----------------------------------------------------------------------------

package types;

    typedef enum logic [1:0] {
        CTRL_DATA = 2'd0,
        CTRL_HEAD = 2'd1,
        CTRL_DONE = 2'd2,
        CTRL_IDLE = 2'd3
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [7:0]  src;
        logic [15:0] data;
    } pkt_t;

endpackage

module bank_arbiter #(
    parameter int NUM_BANKS   = 4,          // at least 2
    parameter int DONE_TARGET = NUM_BANKS   // at least 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_BANKS-1:0]         bank_valid,
    output logic [NUM_BANKS-1:0]         bank_ready,
    input  types::pkt_t                  bank_pkt [NUM_BANKS],
    output logic                         router_valid,
    input  logic                         router_ready,
    output types::pkt_t                  router_pkt,
    output logic [$clog2(NUM_BANKS)-1:0] grant_idx,
    output logic                         all_done
);

    localparam int IDX_W = $clog2(NUM_BANKS);
    localparam int PW    = IDX_W + 1;
    localparam int CNT_W = $clog2(DONE_TARGET + 1);

    localparam logic [IDX_W-1:0]     PTR_INIT = IDX_W'(NUM_BANKS - 1);
    localparam logic [PW-1:0]        N_EXT    = PW'(NUM_BANKS);
    localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(DONE_TARGET);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DONE_TARGET - 1);
    localparam logic [NUM_BANKS-1:0] ONE_HOT0 = {{(NUM_BANKS-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    types::pkt_t            pkt_r;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [IDX_W-1:0]       grant_idx_r;
    logic [CNT_W-1:0]       done_cnt_r;
    logic                   all_done_r;

    logic [NUM_BANKS-1:0]   done_offer_s;
    logic [NUM_BANKS-1:0]   cand_s;
    logic [NUM_BANKS-1:0]   ready_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic                   win_found_s;
    logic                   slot_open_s;
    logic                   accept_s;
    logic                   xfer_s;
    logic                   done_xfer_s;

    // Competing set: if any bank offers CTRL_DONE, only those offers compete.
    always_comb begin
        done_offer_s = {NUM_BANKS{1'b0}};
        for (int i = 0; i < NUM_BANKS; i++) begin
            done_offer_s[i] = bank_valid[i] && (bank_pkt[i].ctrl == types::CTRL_DONE);
        end
        if (|done_offer_s) begin
            cand_s = done_offer_s;
        end else begin
            cand_s = bank_valid;
        end
    end

    // Round-robin search: first candidate at rr_ptr+1, rr_ptr+2, ... (mod NUM_BANKS).
    always_comb begin
        logic [PW-1:0] pos;
        logic          hit;
        win_found_s = 1'b0;
        win_idx_s   = {IDX_W{1'b0}};
        pos         = {PW{1'b0}};
        hit         = 1'b0;
        for (int k = 1; k <= NUM_BANKS; k++) begin
            pos         = {1'b0, rr_ptr_r} + PW'(k);
            pos         = (pos >= N_EXT) ? (pos - N_EXT) : pos;
            hit         = !win_found_s && cand_s[pos[IDX_W-1:0]];
            win_idx_s   = hit ? pos[IDX_W-1:0] : win_idx_s;
            win_found_s = win_found_s || hit;
        end
    end

    // Accept slot and handshake qualifiers; reset forces bank_ready low at once.
    always_comb begin
        slot_open_s = !rst && !all_done_r && ((state_r == ST_EMPTY) || router_ready);
        accept_s    = slot_open_s && win_found_s;
        xfer_s      = (state_r == ST_FULL) && router_ready;
        done_xfer_s = xfer_s && (pkt_r.ctrl == types::CTRL_DONE) && (done_cnt_r != CNT_MAX);
        if (accept_s) begin
            ready_s = ONE_HOT0 << win_idx_s;
        end else begin
            ready_s = {NUM_BANKS{1'b0}};
        end
    end

    // Output-stage next state: a drain and a load on the same edge keep it FULL.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_s = ST_FULL;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (router_ready) begin
                    state_s = accept_s ? ST_FULL : ST_EMPTY;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: state_s = ST_EMPTY;
        endcase
    end

    // Output-stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Packet register, round-robin pointer and debug grant index, all moved by an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_r       <= '0;
            rr_ptr_r    <= PTR_INIT;
            grant_idx_r <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            pkt_r       <= bank_pkt[win_idx_s];
            rr_ptr_r    <= win_idx_s;
            grant_idx_r <= win_idx_s;
        end
    end

    // CTRL_DONE delivery counter; saturates and raises the sticky completion flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt_r <= {CNT_W{1'b0}};
            all_done_r <= 1'b0;
        end else if (done_xfer_s) begin
            done_cnt_r <= done_cnt_r + CNT_W'(1);
            if (done_cnt_r == CNT_LAST) begin
                all_done_r <= 1'b1;
            end
        end
    end

    assign bank_ready   = ready_s;
    assign router_valid = (state_r == ST_FULL);
    assign router_pkt   = pkt_r;
    assign grant_idx    = grant_idx_r;
    assign all_done     = all_done_r;

endmodule

// File: tb/tb_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bank_arbiter
//   Directed scenarios followed by randomized traffic. A transaction-level
//   model predicts grants, the output register and the done count. A scoreboard
//   queue tracks every accepted packet until the router takes it.
// -----------------------------------------------------------------------------

module tb_bank_arbiter;

    localparam int NB = 4;
    localparam int DT = 4;

    logic              clk;
    logic              rst;
    logic [NB-1:0]     bank_valid;
    logic [NB-1:0]     bank_ready;
    types::pkt_t       bank_pkt [NB];
    logic              router_valid;
    logic              router_ready;
    types::pkt_t       router_pkt;
    logic [1:0]        grant_idx;
    logic              all_done;

    int checks = 0;
    int errors = 0;

    // model state
    bit            m_full;
    types::pkt_t   m_pkt;
    int            m_rr;
    int            m_grant;
    int            m_cnt;
    bit            m_done;
    types::pkt_t   acc_q[$];
    int            wait_cnt [NB];
    int            max_wait  = 0;
    int            accepted  = 0;
    int            delivered = 0;
    int            discarded = 0;
    int            seq       = 1;
    logic [NB-1:0] last_rdy;

    bank_arbiter #(.NUM_BANKS(NB), .DONE_TARGET(DT)) dut (
        .clk          (clk),
        .rst          (rst),
        .bank_valid   (bank_valid),
        .bank_ready   (bank_ready),
        .bank_pkt     (bank_pkt),
        .router_valid (router_valid),
        .router_ready (router_ready),
        .router_pkt   (router_pkt),
        .grant_idx    (grant_idx),
        .all_done     (all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic types::pkt_t mk(input types::ctrl_t c, input int src);
        types::pkt_t p;
        p.ctrl = c;
        p.src  = 8'(src);
        p.data = 16'(seq);
        seq++;
        return p;
    endfunction

    function automatic bit any_done_offer();
        bit a = 1'b0;
        for (int i = 0; i < NB; i++)
            if (bank_valid[i] && bank_pkt[i].ctrl == types::CTRL_DONE) a = 1'b1;
        return a;
    endfunction

    function automatic bit in_class(input int i);
        return bank_valid[i] && (!any_done_offer() || bank_pkt[i].ctrl == types::CTRL_DONE);
    endfunction

    // winner = competing bank with smallest rotational distance after m_rr
    function automatic int pick();
        int best  = -1;
        int bestd = NB;
        int d;
        for (int i = 0; i < NB; i++) begin
            if (in_class(i)) begin
                d = (i - m_rr - 1 + 2 * NB) % NB;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic void model_reset();
        discarded += acc_q.size();
        acc_q.delete();
        m_full  = 1'b0;
        m_rr    = NB - 1;
        m_grant = 0;
        m_cnt   = 0;
        m_done  = 1'b0;
        for (int i = 0; i < NB; i++) wait_cnt[i] = 0;
    endfunction

    // One cycle: check outputs against the model, advance the model, cross the edge.
    task automatic step();
        bit            slot;
        int            w;
        logic [NB-1:0] exp_rdy;
        types::pkt_t   head;
        #1;
        slot    = !m_done && (!m_full || router_ready);
        w       = pick();
        exp_rdy = (slot && w >= 0) ? (4'b0001 << w) : 4'b0000;
        chk("router_valid", 64'(router_valid), 64'(m_full));
        if (m_full) chk("router_pkt", 64'(router_pkt), 64'(m_pkt));
        chk("bank_ready", 64'(bank_ready), 64'(exp_rdy));
        chk("ready_onehot", 64'($countones(bank_ready) <= 1), 64'd1);
        chk("grant_idx", 64'(grant_idx), 64'(m_grant));
        chk("all_done", 64'(all_done), 64'(m_done));
        last_rdy = bank_ready;
        for (int i = 0; i < NB; i++) begin
            if (!bank_valid[i]) wait_cnt[i] = 0;
            else if (slot && w >= 0) begin
                if (w == i || !in_class(i)) wait_cnt[i] = 0;
                else begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
            end
        end
        if (m_full && router_ready) begin
            if (acc_q.size() > 0) begin
                head = acc_q.pop_front();
                chk("delivered_pkt", 64'(router_pkt), 64'(head));
            end else begin
                chk("scoreboard_underflow", 64'(acc_q.size()), 64'd1);
            end
            delivered++;
            if (m_pkt.ctrl == types::CTRL_DONE && m_cnt < DT) begin
                m_cnt++;
                if (m_cnt == DT) m_done = 1'b1;
            end
            m_full = 1'b0;
        end
        if (slot && w >= 0) begin
            m_pkt   = bank_pkt[w];
            m_full  = 1'b1;
            m_rr    = w;
            m_grant = w;
            acc_q.push_back(bank_pkt[w]);
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert rst between edges and check that outputs clear without a clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_router_valid", 64'(router_valid), 64'd0);
        chk("rst_bank_ready", 64'(bank_ready), 64'd0);
        chk("rst_all_done", 64'(all_done), 64'd0);
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] order [6];
        types::pkt_t   held;
        int            r;

        rst          = 1'b1;
        bank_valid   = '0;
        router_ready = 1'b0;
        for (int i = 0; i < NB; i++) bank_pkt[i] = mk(types::CTRL_DATA, i);
        model_reset();
        async_reset();

        // All banks valid, non-DONE, router always ready: rotation 0,1,2,3,0,1
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001; order[5] = 4'b0010;
        bank_valid   = 4'b1111;
        router_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("rotation", 64'(last_rdy), 64'(order[c]));
            chk("stream_valid", 64'(router_valid), 64'd1);
            for (int i = 0; i < NB; i++)
                if (last_rdy[i]) bank_pkt[i] = mk(types::CTRL_DATA, i);
        end

        // Banks 1 and 3, five cycles of backpressure after the first accept
        async_reset();
        bank_pkt[1]  = mk(types::CTRL_DATA, 1);
        bank_pkt[3]  = mk(types::CTRL_HEAD, 3);
        held         = bank_pkt[1];
        bank_valid   = 4'b1010;
        router_ready = 1'b1;
        step();
        chk("bp_first_grant", 64'(last_rdy), 64'(4'b0010));
        bank_valid   = 4'b1000;
        router_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_held_pkt", 64'(router_pkt), 64'(held));
            chk("bp_no_ready", 64'(last_rdy), 64'd0);
        end
        router_ready = 1'b1;
        step();
        chk("bp_resume_grant", 64'(last_rdy), 64'(4'b1000));

        // DONE priority over rotation order
        async_reset();
        bank_pkt[0]  = mk(types::CTRL_DATA, 0);
        bank_pkt[2]  = mk(types::CTRL_DONE, 2);
        bank_valid   = 4'b0101;
        router_ready = 1'b1;
        step();
        chk("done_priority", 64'(last_rdy), 64'(4'b0100));

        // Four DONE deliveries with one-cycle stalls between them
        async_reset();
        bank_pkt[0] = mk(types::CTRL_DONE, 0);
        bank_valid  = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            router_ready = (c % 2 == 0);
            step();
            chk("all_done_edge", 64'(all_done), 64'(c >= 8));
            if (last_rdy[0]) bank_pkt[0] = mk(types::CTRL_DONE, 0);
        end
        bank_valid = 4'b1111;
        #1;
        chk("ready_after_done", 64'(bank_ready), 64'd0);
        chk("held_after_done", 64'(router_valid), 64'd1);
        #1;

        // Reset while FULL, then bank 0 wins first
        async_reset();
        bank_valid   = 4'b0100;
        router_ready = 1'b0;
        step();
        chk("full_before_rst", 64'(router_valid), 64'd1);
        async_reset();
        bank_valid   = 4'b1111;
        router_ready = 1'b1;
        step();
        chk("first_after_rst", 64'(last_rdy), 64'(4'b0001));

        // Random traffic; offers held until accepted
        async_reset();
        bank_valid = '0;
        for (int c = 0; c < 600; c++) begin
            if (c % 75 == 74) begin
                async_reset();
                bank_valid = '0;
            end
            for (int i = 0; i < NB; i++) begin
                if (!bank_valid[i] && $urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, 19);
                    bank_pkt[i]   = mk((r == 0) ? types::CTRL_DONE :
                                       (r < 10) ? types::CTRL_DATA : types::CTRL_HEAD, i);
                    bank_valid[i] = 1'b1;
                end
            end
            router_ready = ($urandom_range(0, 3) != 0);
            step();
            for (int i = 0; i < NB; i++)
                if (last_rdy[i]) bank_valid[i] = 1'b0;
        end
        bank_valid   = '0;
        router_ready = 1'b1;
        step();
        step();
        chk("drained", 64'(acc_q.size()), 64'd0);
        chk("no_loss_no_dup", 64'(delivered + discarded), 64'(accepted));
        chk("fairness_bound", 64'(max_wait < NB), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
